uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver. Successor to the fixed 8-bit receiver, adding:
- configurable data width, parity mode and stop-bit count
- mid-bit sampling from an external oversample tick
- false-start rejection
- parity, framing and overrun error reporting
- valid/ready output handshake

Sits between the pad-side serial line and the byte consumer (FIFO or register interface). The baud/oversample tick comes from the shared baud generator.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_os.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_os.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings and receiver FSM states.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with mid-bit sampling, error flags and valid/ready output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a high-to-low transition of the line
// ST_START  | half-bit wait, then confirm start bit (reject glitches)
// ST_DATA   | sampling DATA_BITS payload bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling STOP_BITS stop bits
// ST_DONE   | one clk: hand the frame to the output register or drop it
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVS         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 os_tick,
    input  logic                 d_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(OVS / 2 - 2);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(OVS - 1);
    localparam logic [3:0]    DATA_LOAD = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LOAD = 4'(STOP_BITS - 1);
    localparam logic          PAR_INV   = (PARITY_MODE == PAR_ODD);

    uart_rx_state_t       state;
    logic                 line;
    logic                 line_prev;
    logic [CW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;
    logic                 sample;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (d_in),
        .q     (line)
    );

    // A bit is sampled on the tick where the down-counter has reached zero.
    assign sample = os_tick && (tick_cnt == '0);
    assign busy   = (state != ST_IDLE);

    // Receiver FSM, bit timers and the registered output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            line_prev  <= 1'b1;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // line_prev lets IDLE arm only on a falling edge, so a break
            // (line stuck low) yields exactly one frame.
            if (os_tick) begin
                line_prev <= line;
            end
            if (os_tick && (tick_cnt != '0)) begin
                tick_cnt <= tick_cnt - CW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (os_tick && !line && line_prev) begin
                        state    <= ST_START;
                        tick_cnt <= HALF_LOAD;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        if (line) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DATA;
                            tick_cnt <= BIT_LOAD;
                            bit_cnt  <= DATA_LOAD;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        tick_cnt <= BIT_LOAD;
                        shreg    <= {line, shreg[DATA_BITS-1:1]};
                        if (bit_cnt != 4'd0) begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end else if (PARITY_MODE != PAR_NONE) begin
                            state <= ST_PARITY;
                        end else begin
                            state   <= ST_STOP;
                            bit_cnt <= STOP_LOAD;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        perr     <= (line != ((^shreg) ^ PAR_INV));
                        state    <= ST_STOP;
                        tick_cnt <= BIT_LOAD;
                        bit_cnt  <= STOP_LOAD;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        tick_cnt <= BIT_LOAD;
                        if (!line) begin
                            ferr <= 1'b1;
                        end
                        if (bit_cnt != 4'd0) begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A word consumed in this same clk frees the register.
                    if (!rx_valid || rx_ready) begin
                        rx_data    <= shreg;
                        parity_err <= perr;
                        frame_err  <= ferr;
                        rx_valid   <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: three configurations (8E1, 8O1, 7N2).
module tb_uart_rx_os;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rst_7   = 1'b0;
    logic os_tick = 1'b0;
    logic tick_en = 1'b0;
    int   div     = 0;

    logic din [3];
    logic rdy [3];
    logic val [3];
    logic pe  [3];
    logic fe  [3];
    logic ov  [3];
    logic busy[3];
    logic [7:0] data_def;
    logic [7:0] data_odd;
    logic [6:0] data_7;

    int checks = 0;
    int errors = 0;
    int ovc[3] = '{0, 0, 0};

    uart_rx_os #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVS(16)) u_def (
        .clk(clk), .reset(rst_n), .os_tick(os_tick), .d_in(din[0]),
        .rx_data(data_def), .rx_valid(val[0]), .rx_ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(busy[0]));

    uart_rx_os #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVS(16)) u_odd (
        .clk(clk), .reset(rst_n), .os_tick(os_tick), .d_in(din[1]),
        .rx_data(data_odd), .rx_valid(val[1]), .rx_ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(busy[1]));

    uart_rx_os #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .OVS(16)) u_7n2 (
        .clk(clk), .reset(rst_7), .os_tick(os_tick), .d_in(din[2]),
        .rx_data(data_7), .rx_valid(val[2]), .rx_ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(busy[2]));

    always #5 clk = ~clk;

    // Oversample tick: one clk in four, changed on the falling edge.
    always @(negedge clk) begin
        if (tick_en) begin
            os_tick = (div == 3);
            div = (div + 1) % 4;
        end else begin
            os_tick = 1'b0;
        end
    end

    // Count overrun pulses per instance.
    always @(negedge clk) begin
        if (ov[0]) ovc[0]++;
        if (ov[1]) ovc[1]++;
        if (ov[2]) ovc[2]++;
    end

    function automatic logic [31:0] get_data(input int inst);
        case (inst)
            0: return {24'd0, data_def};
            1: return {24'd0, data_odd};
            default: return {25'd0, data_7};
        endcase
    endfunction

    // Reference model: serial frame from the protocol rules, LSB first.
    function automatic logic [15:0] mk_frame(input logic [8:0] data, input int nd, input int pm,
                                             input logic pbit, input logic [1:0] stops, input int ns);
        logic [15:0] b;
        int k;
        b = '0;
        k = 1;
        for (int i = 0; i < nd; i++) begin
            b[k] = data[i];
            k++;
        end
        if (pm != 0) begin
            b[k] = pbit;
            k++;
        end
        for (int j = 0; j < ns; j++) begin
            b[k] = stops[j];
            k++;
        end
        return b;
    endfunction

    function automatic int frame_len(input int nd, input int pm, input int ns);
        return 1 + nd + ((pm != 0) ? 1 : 0) + ns;
    endfunction

    function automatic logic good_parity(input logic [8:0] data, input int nd, input int pm);
        logic x;
        x = 1'b0;
        for (int i = 0; i < nd; i++) x ^= data[i];
        return (pm == 2) ? ~x : x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            do @(posedge clk); while (!os_tick);
        end
        #1;
    endtask

    task automatic set_din(input int inst, input logic v);
        din[inst] = v;
    endtask

    // mode 0: plain; 1: pulse rx_ready in the DONE clk; 2: check rx_valid latency.
    task automatic send(input int inst, input logic [15:0] bits, input int n, input int mode);
        set_din(inst, 1'b1);
        tick_wait(4);
        for (int i = 0; i < n; i++) begin
            set_din(inst, bits[i]);
            if (i == n - 1 && mode != 0) begin
                tick_wait(8);
                if (mode == 1) begin
                    rdy[inst] = 1'b1;
                    @(posedge clk);
                    #1;
                    rdy[inst] = 1'b0;
                end else begin
                    check("latency_pre", {31'd0, val[inst]}, 32'd0);
                    @(posedge clk);
                    #1;
                    check("latency_post", {31'd0, val[inst]}, 32'd1);
                end
                tick_wait(8);
            end else begin
                tick_wait(16);
            end
        end
        set_din(inst, 1'b1);
    endtask

    task automatic wait_valid(input int inst, input int budget);
        int n;
        n = 0;
        while (!val[inst] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("valid_timeout", {31'd0, val[inst]}, 32'd1);
    endtask

    task automatic consume(input int inst);
        rdy[inst] = 1'b1;
        @(posedge clk);
        #1;
        rdy[inst] = 1'b0;
        check("valid_drop", {31'd0, val[inst]}, 32'd0);
    endtask

    task automatic expect_word(input string tag, input int inst, input logic [31:0] d,
                               input logic p, input logic f);
        wait_valid(inst, 200);
        check({tag, "_data"}, get_data(inst), d);
        check({tag, "_perr"}, {31'd0, pe[inst]}, {31'd0, p});
        check({tag, "_ferr"}, {31'd0, fe[inst]}, {31'd0, f});
    endtask

    initial begin
        int ov0;
        logic [8:0] rd;
        logic rp;
        logic rs;
        for (int i = 0; i < 3; i++) begin
            din[i] = 1'b1;
            rdy[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, val[0]}, 32'd0);
        check("rst_data", get_data(0), 32'd0);
        check("rst_perr", {31'd0, pe[0]}, 32'd0);
        check("rst_ferr", {31'd0, fe[0]}, 32'd0);
        check("rst_ovr", {31'd0, ov[0]}, 32'd0);
        rst_n = 1'b1;
        rst_7 = 1'b1;
        tick_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy[0]}, 32'd0);

        // 0xA5, even parity correct; hold, then consume with ticks stopped.
        send(0, mk_frame(9'hA5, 8, 1, good_parity(9'hA5, 8, 1), 2'b11, 1), 11, 2);
        expect_word("a5", 0, 32'hA5, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("hold_valid", {31'd0, val[0]}, 32'd1);
        check("hold_data", get_data(0), 32'hA5);
        check("idle_busy", {31'd0, busy[0]}, 32'd0);
        tick_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        consume(0);
        tick_en = 1'b1;

        // Parity: 0x01 with parity bit 0 is wrong for even, right for odd.
        send(0, mk_frame(9'h01, 8, 1, 1'b0, 2'b11, 1), 11, 0);
        expect_word("par_even", 0, 32'h01, 1'b1, 1'b0);
        consume(0);
        send(1, mk_frame(9'h01, 8, 2, 1'b0, 2'b11, 1), 11, 0);
        expect_word("par_odd", 1, 32'h01, 1'b0, 1'b0);
        consume(1);

        // Framing error then clean frame.
        send(0, mk_frame(9'h3C, 8, 1, good_parity(9'h3C, 8, 1), 2'b00, 1), 11, 0);
        expect_word("ferr", 0, 32'h3C, 1'b0, 1'b1);
        consume(0);
        send(0, mk_frame(9'h55, 8, 1, good_parity(9'h55, 8, 1), 2'b11, 1), 11, 0);
        expect_word("clean", 0, 32'h55, 1'b0, 1'b0);
        consume(0);

        // Four-tick glitch is rejected at the mid-start sample.
        tick_wait(4);
        set_din(0, 1'b0);
        tick_wait(4);
        set_din(0, 1'b1);
        tick_wait(3);
        check("glitch_busy_hi", {31'd0, busy[0]}, 32'd1);
        tick_wait(1);
        check("glitch_busy_lo", {31'd0, busy[0]}, 32'd0);
        check("glitch_valid", {31'd0, val[0]}, 32'd0);

        // Overrun: second frame dropped while first is held.
        send(0, mk_frame(9'h11, 8, 1, good_parity(9'h11, 8, 1), 2'b11, 1), 11, 0);
        expect_word("ovr_first", 0, 32'h11, 1'b0, 1'b0);
        ov0 = ovc[0];
        send(0, mk_frame(9'h22, 8, 1, good_parity(9'h22, 8, 1), 2'b11, 1), 11, 0);
        check("ovr_data", get_data(0), 32'h11);
        check("ovr_valid", {31'd0, val[0]}, 32'd1);
        check("ovr_pulses", ovc[0] - ov0, 32'd1);
        consume(0);

        // Consume in the DONE clk: new word loads, no overrun.
        send(0, mk_frame(9'h11, 8, 1, good_parity(9'h11, 8, 1), 2'b11, 1), 11, 0);
        expect_word("same_first", 0, 32'h11, 1'b0, 1'b0);
        ov0 = ovc[0];
        send(0, mk_frame(9'h22, 8, 1, good_parity(9'h22, 8, 1), 2'b11, 1), 11, 1);
        check("same_data", get_data(0), 32'h22);
        check("same_valid", {31'd0, val[0]}, 32'd1);
        check("same_no_ovr", ovc[0] - ov0, 32'd0);
        consume(0);

        // 7N2: second stop bit low.
        send(2, mk_frame(9'h7F, 7, 0, 1'b0, 2'b01, 2), frame_len(7, 0, 2), 0);
        expect_word("stop2", 2, 32'h7F, 1'b0, 1'b1);

        // Reset mid-DATA aborts and discards the held word.
        send(2, mk_frame(9'h2A, 7, 0, 1'b0, 2'b11, 2), 4, 0);
        check("mid_busy", {31'd0, busy[2]}, 32'd1);
        rst_7 = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, val[2]}, 32'd0);
        check("mid_rst_busy", {31'd0, busy[2]}, 32'd0);
        check("mid_rst_data", get_data(2), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_7 = 1'b1;
        tick_wait(20);
        check("post_rst_valid", {31'd0, val[2]}, 32'd0);
        check("post_rst_ferr", {31'd0, fe[2]}, 32'd0);
        send(2, mk_frame(9'h2A, 7, 0, 1'b0, 2'b11, 2), frame_len(7, 0, 2), 0);
        expect_word("post_rst", 2, 32'h2A, 1'b0, 1'b0);
        consume(2);

        // Randomised frames against the reference model.
        for (int r = 0; r < 8; r++) begin
            rd = 9'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 4) != 0);
            send(0, mk_frame(rd, 8, 1, rp, {1'b1, rs}, 1), 11, 0);
            expect_word("rand", 0, {23'd0, rd}, rp != good_parity(rd, 8, 1), !rs);
            consume(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
